// File: rtl/noc_rr_arbiter5.sv
// noc_rr_arbiter5: round-robin wormhole arbiter for one output port of a 5-port router
module noc_rr_arbiter5 #(
  parameter int NUM_INPUTS = 5,
  parameter int MAX_FLITS  = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] Req,
  input  logic [NUM_INPUTS-1:0] Tail,
  input  logic                  Ready,
  output logic [NUM_INPUTS-1:0] Gnt,
  output logic [NUM_INPUTS-1:0] Ack,
  output logic                  Fire,
  output logic                  Err
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, gidx, gidx_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_INPUTS-1:0] gnt_n;
  logic err_n, release_pkt;
  assign Ack  = Gnt & Req & {NUM_INPUTS{Ready}};
  assign Fire = |Ack;
  // Walk offsets from farthest to nearest so the nearest requester from ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      int s;
      s = int'(ptr) + k;
      s = s >= NUM_INPUTS ? s - NUM_INPUTS : s;
      if (Req[s]) pick = 3'(s);
    end
  end
  assign release_pkt = Fire && (Tail[gidx] || cnt == CNT_W'(MAX_FLITS - 1));
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    cnt_n   = cnt;
    gnt_n   = Gnt;
    err_n   = 1'b0;
    if (state == IDLE) begin
      if (|Req) begin
        state_n = LOCKED;
        gidx_n  = pick;
        cnt_n   = '0;
        gnt_n   = NUM_INPUTS'(1) << pick;
      end
    end else if (Fire) begin
      cnt_n = cnt + CNT_W'(1);
      if (release_pkt) begin
        state_n = IDLE;
        gnt_n   = '0;
        ptr_n   = gidx == 3'd4 ? 3'd0 : gidx + 3'd1;
        err_n   = !Tail[gidx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      cnt   <= '0;
      Gnt   <= '0;
      Err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      cnt   <= cnt_n;
      Gnt   <= gnt_n;
      Err   <= err_n;
    end
  end
endmodule

// File: tb/tb_noc_rr_arbiter5.sv
// tb_noc_rr_arbiter5: directed scenarios plus random traffic against a packet-level reference model
module tb_noc_rr_arbiter5;
  localparam int MAXF = 16;
  logic clk = 0, rst_n = 0, Ready = 0;
  logic [4:0] Req = 0, Tail = 0, Gnt, Ack;
  logic Fire, Err;
  int total = 0, bad = 0;
  int m_owner = -1, m_ptr = 0, m_flits = 0;
  bit m_err = 0;
  logic [4:0] exp_gnt, exp_ack;
  logic exp_err;

  noc_rr_arbiter5 dut (.clk(clk), .rst_n(rst_n), .Req(Req), .Tail(Tail), .Ready(Ready),
                       .Gnt(Gnt), .Ack(Ack), .Fire(Fire), .Err(Err));

  always #5 clk = ~clk;

  task automatic mreset();
    m_owner = -1; m_ptr = 0; m_flits = 0; m_err = 0;
  endtask

  // Inputs change just after the falling edge; expectations come from the model's view of this cycle.
  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic rd);
    Req = r; Tail = t; Ready = rd;
    #1;
    exp_gnt = m_owner < 0 ? 5'd0 : 5'(1 << m_owner);
    exp_ack = (m_owner >= 0 && r[m_owner] && rd) ? exp_gnt : 5'd0;
    exp_err = m_err;
  endtask

  // Advance the model by one packet-level rule application, then move to the next falling edge.
  task automatic tick();
    int k;
    m_err = 0;
    if (m_owner < 0) begin
      if (Req != 0) begin
        for (k = 0; k < 5; k++) if (Req[(m_ptr + k) % 5]) break;
        m_owner = (m_ptr + k) % 5;
        m_flits = 0;
      end
    end else if (Req[m_owner] && Ready) begin
      m_flits++;
      if (Tail[m_owner] || m_flits == MAXF) begin
        m_err = !Tail[m_owner];
        m_ptr = (m_owner + 1) % 5;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    Req = 5'b11111; Ready = 1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({Gnt, Ack, Err} !== 11'd0) begin
      bad++; $display("FAIL reset_hold gnt=%b ack=%b err=%b want all zero", Gnt, Ack, Err);
    end
    @(negedge clk);
    rst_n = 1; mreset();
    drive(5'b11111, 5'b11111, 1); tick();
    drive(5'b11111, 5'b11111, 1);
    total++;
    if (Gnt !== 5'b00001) begin bad++; $display("FAIL reset_first_grant gnt=%b want 00001", Gnt); end
    tick();
    drive(5'b00000, 5'b00000, 1); tick();
  endtask

  task automatic test_basic();
    logic [4:0] wg [6] = '{5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b10000};
    logic [4:0] tl [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b10000};
    int acks = 0;
    for (int c = 0; c < 6; c++) begin
      drive(c < 4 ? 5'b10100 : 5'b10000, tl[c], 1);
      acks += int'(Ack[2]);
      total++;
      if (Gnt !== wg[c] || Gnt !== exp_gnt || Ack !== exp_ack || Fire !== |exp_ack || Err !== exp_err) begin
        bad++; $display("FAIL basic c=%0d gnt=%b ack=%b err=%b want gnt=%b ack=%b err=%b", c, Gnt, Ack, Err, wg[c], exp_ack, exp_err);
      end
      tick();
    end
    total++;
    if (acks != 3) begin bad++; $display("FAIL basic_ack2_count got=%0d want 3", acks); end
    drive(5'b00000, 5'b00000, 1); tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] seq [11] = '{5'b00001, 0, 5'b00010, 0, 5'b00100, 0, 5'b01000, 0, 5'b10000, 0, 5'b00001};
    drive(5'b11111, 5'b11111, 1); tick();
    for (int c = 0; c < 11; c++) begin
      drive(5'b11111, 5'b11111, 1);
      total++;
      if (Gnt !== seq[c] || Gnt !== exp_gnt || Ack !== exp_ack || Fire !== |exp_ack || Err !== exp_err) begin
        bad++; $display("FAIL round_robin c=%0d gnt=%b want %b ack=%b want %b", c, Gnt, seq[c], Ack, exp_ack);
      end
      tick();
    end
    drive(5'b00000, 5'b00000, 1); tick();
  endtask

  task automatic test_backpressure();
    drive(5'b00010, 5'b00000, 1); tick();
    drive(5'b00010, 5'b00000, 1); tick();
    for (int c = 0; c < 4; c++) begin
      drive(5'b00010, 5'b00000, 0);
      total++;
      if (Gnt !== 5'b00010 || Ack !== 5'b00000 || Fire !== 1'b0 || Gnt !== exp_gnt) begin
        bad++; $display("FAIL backpressure_stall c=%0d gnt=%b ack=%b fire=%b want 00010/00000/0", c, Gnt, Ack, Fire);
      end
      tick();
    end
    for (int c = 0; c < 15; c++) begin
      drive(5'b00010, c == 14 ? 5'b00010 : 5'b00000, 1);
      total++;
      if (Gnt !== 5'b00010 || Ack !== exp_ack || Ack !== 5'b00010 || Err !== 1'b0) begin
        bad++; $display("FAIL backpressure_resume c=%0d gnt=%b ack=%b err=%b want 00010/00010/0", c, Gnt, Ack, Err);
      end
      tick();
    end
    drive(5'b00000, 5'b00000, 1);
    total++;
    if (Gnt !== 5'b00000 || Err !== 1'b0) begin
      bad++; $display("FAIL backpressure_release gnt=%b err=%b want 00000/0", Gnt, Err);
    end
    tick();
  endtask

  task automatic test_hold();
    drive(5'b01000, 5'b00000, 1); tick();
    drive(5'b01000, 5'b00000, 1); tick();
    for (int c = 0; c < 2; c++) begin
      drive(5'b00001, 5'b00000, 1);
      total++;
      if (Gnt !== 5'b01000 || Ack[0] !== 1'b0 || Fire !== 1'b0 || Gnt !== exp_gnt) begin
        bad++; $display("FAIL hold c=%0d gnt=%b ack=%b fire=%b want 01000/00000/0", c, Gnt, Ack, Fire);
      end
      tick();
    end
    drive(5'b01001, 5'b01000, 1);
    total++;
    if (Ack !== 5'b01000 || Ack !== exp_ack) begin bad++; $display("FAIL hold_tail ack=%b want 01000", Ack); end
    tick();
    drive(5'b00000, 5'b00000, 1); tick();
  endtask

  task automatic test_watchdog();
    drive(5'b01000, 5'b00000, 1); tick();
    for (int c = 0; c < 16; c++) begin
      drive(5'b01000, 5'b00000, 1);
      total++;
      if (Ack !== 5'b01000 || Err !== 1'b0 || Ack !== exp_ack) begin
        bad++; $display("FAIL watchdog_flit c=%0d ack=%b err=%b want 01000/0", c, Ack, Err);
      end
      tick();
    end
    drive(5'b11001, 5'b00000, 1);
    total++;
    if (Err !== 1'b1 || Gnt !== 5'b00000 || Err !== exp_err) begin
      bad++; $display("FAIL watchdog_err err=%b gnt=%b want 1/00000", Err, Gnt);
    end
    tick();
    drive(5'b11001, 5'b10000, 1);
    total++;
    if (Gnt !== 5'b10000 || Err !== 1'b0 || Gnt !== exp_gnt) begin
      bad++; $display("FAIL watchdog_next gnt=%b err=%b want 10000/0", Gnt, Err);
    end
    tick();
    drive(5'b00000, 5'b00000, 1); tick();
  endtask

  task automatic test_random();
    logic [4:0] r, t;
    for (int c = 0; c < 600; c++) begin
      r = 5'($urandom);
      t = 0;
      for (int i = 0; i < 5; i++) t[i] = $urandom_range(0, 7) == 0;
      drive(r, t, $urandom_range(0, 3) != 0);
      total++;
      if (Gnt !== exp_gnt || Ack !== exp_ack || Fire !== |exp_ack || Err !== exp_err ||
          (Ack & ~Gnt) != 0 || $countones(Gnt) > 1) begin
        bad++; $display("FAIL random c=%0d gnt=%b ack=%b fire=%b err=%b want %b %b %b %b",
                        c, Gnt, Ack, Fire, Err, exp_gnt, exp_ack, |exp_ack, exp_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(5'b11111, 5'b00000, 1); tick();
    drive(5'b11111, 5'b00000, 1); tick();
    drive(5'b11111, 5'b00000, 1);
    #1 rst_n = 0;
    #1;
    total++;
    if (Gnt !== 5'b00000 || Ack !== 5'b00000 || Err !== 1'b0) begin
      bad++; $display("FAIL reset_async gnt=%b ack=%b err=%b want all zero", Gnt, Ack, Err);
    end
    @(negedge clk);
    rst_n = 1; mreset();
    drive(5'b11111, 5'b11111, 1); tick();
    drive(5'b11111, 5'b11111, 1);
    total++;
    if (Gnt !== 5'b00001) begin bad++; $display("FAIL reset_mid_grant gnt=%b want 00001", Gnt); end
    tick();
  endtask

  initial begin
    mreset();
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_hold();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_rr_arbiter5.md
Name: noc_rr_arbiter5

Overview:
- Per-output-port wormhole arbiter for the 5-port router: inputs Local, North, East, South and West.
- Picks one of five requesting input ports with round-robin priority.
- Holds the grant until that packet's tail flit has transferred.
- Drives the one-hot Gnt select of the downstream 5:1 crossbar mux of the same output port, and the pop strobes back to the input buffers.

Parameters:
- NUM_INPUTS, 5, number of input ports; only 5 is supported (one-hot encodings are 5 bits).
- MAX_FLITS, 16, watchdog limit: maximum flits per packet before forced release; legal range 2..2^CNT_W-1.
- CNT_W, 5, width of the internal flit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Req  input  NUM_INPUTS  Req[i]=1: input i holds a valid flit routed to this output.
- Tail  input  NUM_INPUTS  Tail[i]=1: the flit at input i is a tail flit; meaningful only when Req[i]=1.
- Ready  input  1  downstream buffer can accept a flit this cycle.
- Gnt  output  NUM_INPUTS  registered; one-hot or all-zero; crossbar select.
- Ack  output  NUM_INPUTS  combinational pop strobe: Gnt & Req & {5{Ready}}.
- Fire  output  1  combinational: |Ack; a flit transfers this cycle.
- Err  output  1  registered one-cycle pulse when the watchdog force-releases a lock.

Behaviour:
- Reset (rst_n=0, asynchronous): Gnt=0, Err=0, state=IDLE, ptr=0, cnt=0. Ack and Fire are therefore 0.
- Internal state:
  - 2-state FSM: IDLE and LOCKED.
  - ptr: 3-bit round-robin pointer, 0..4.
  - gidx: 3-bit granted index.
  - cnt: CNT_W-bit flit counter.
- IDLE:
  - If Req==0: stay in IDLE, Gnt=0.
  - Else: select the first i with Req[i]=1, searching ptr, ptr+1, … with modulo-5 wrap.
  - Next edge: Gnt<=onehot(i), gidx<=i, cnt<=0, state<=LOCKED.
  - Latency from Req to Gnt is 1 cycle. No flit transfers in IDLE.
- LOCKED:
  - Gnt is held constant and the grant is never re-arbitrated mid-packet.
  - If the granted input drops Req, the lock is kept and no transfer occurs (wormhole hold).
  - Ready=0 means no Fire, and cnt holds.
- On Fire with Tail[gidx]=1 (normal release):
  - Next edge: Gnt<=0, ptr<=(gidx+1) mod 5, state<=IDLE.
  - This leaves one idle bubble cycle before the next grant.
  - A single-flit packet (head is also tail) releases on its first Fire.
- On Fire with Tail[gidx]=0:
  - cnt<=cnt+1.
  - If cnt==MAX_FLITS-1 (this is the MAX_FLITS-th flit with no tail seen), force release: Gnt<=0, ptr<=(gidx+1) mod 5, state<=IDLE, Err<=1 for exactly one cycle.
- Err is 0 in every other cycle.
- Requests from non-granted inputs are ignored while LOCKED; they see Ack=0.
- Simultaneous tail release and new requests: new requests are evaluated in the following IDLE cycle against the updated ptr.
- Fairness: a continuously requesting input waits at most 4 packets.
- Pointer wrap: gidx=4 release sets ptr=0.
- Gnt never has more than one bit set. Gnt=0 leaves the crossbar output high-impedance; this is legal.
- Invariant: Ack[i]=1 implies Gnt[i]=1.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation with Req=5'b11111 -> Gnt=0, Ack=0, Err=0 asynchronously. First grant after release of reset is 5'b00001.
2. Basic grant, ptr=0, Ready=1:
   - Req=5'b10100 -> Gnt=5'b00100 one cycle later.
   - 3-flit packet on input 2, tail on the 3rd Fire -> Ack[2] pulses 3 times, then Gnt=0 for one cycle, then Gnt=5'b10000.
3. Round-robin: Req=5'b11111, Tail=5'b11111, Ready=1 held -> Gnt sequence 00001, 0, 00010, 0, 00100, 0, 01000, 0, 10000, 0, 00001.
4. Backpressure:
   - During a lock on input 1, drive Ready=0 for 4 cycles -> Gnt stays 5'b00010, Ack=0, Fire=0.
   - Then restore Ready=1 -> the remaining flits transfer, and the flit count excludes the stalled cycles.
5. Hold on Req drop: granted input 3 deasserts Req for 2 cycles mid-packet while input 0 requests -> Gnt stays 5'b01000 and Ack[0] stays 0.
6. Watchdog: input 3 sends 16 non-tail flits with Ready=1 -> the cycle after the 16th Fire shows Err=1 for one cycle and Gnt=0. The next grant honours ptr=4: with Req=5'b11001 pending, Gnt=5'b10000.
